// File: rtl/trng_digitizer.sv
// -----------------------------------------------------------------------------
// trng_digitizer
//
// Producer side of the TRNG serial bit interface. The raw asynchronous entropy
// bit is synchronized, decimated by a programmable divider and optionally
// debiased with a von Neumann pair extractor. Every emitted bit is presented
// on digi_data_out together with a one-cycle digi_data_vld strobe, and a
// saturating 16-bit counter tracks how many bits have been emitted.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   synchronous, active-high reset
//   ro_raw         in   raw entropy bit, asynchronous to clk
//   digi_en        in   block enable; low holds divider and debiaser idle
//   sample_div     in   sample period minus one (DIV_W bits)
//   vn_en          in   von Neumann debias enable
//   cnt_clr        in   synchronous clear of digi_bit_cnt (wins over counting)
//   digi_data_out  out  emitted bit; holds between strobes
//   digi_data_vld  out  one-cycle strobe qualifying digi_data_out
//   digi_bit_cnt   out  saturating count of emitted bits
// -----------------------------------------------------------------------------
module trng_digitizer #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_raw,
    input  logic             digi_en,
    input  logic [DIV_W-1:0] sample_div,
    input  logic             vn_en,
    input  logic             cnt_clr,
    output logic             digi_data_out,
    output logic             digi_data_vld,
    output logic [15:0]      digi_bit_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PAIR = 1'b1
    } vn_state_t;

    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [15:0]      CNT_MAX  = 16'hFFFF;
    localparam logic [15:0]      CNT_ONE  = 16'h0001;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s_bit;
    logic [DIV_W-1:0]       r_div_cnt;
    logic                   w_smp;
    vn_state_t              r_state;
    vn_state_t              w_state_nxt;
    logic                   r_first;
    logic                   w_first_nxt;
    logic                   r_data_out;
    logic                   w_data_nxt;
    logic                   r_data_vld;
    logic                   w_vld_nxt;
    logic [15:0]            r_bit_cnt;

    assign w_s_bit = r_sync[SYNC_STAGES-1];

    // A >= compare (rather than ==) makes a shrinking sample_div strobe at
    // once instead of letting the counter run on to wrap-around.
    assign w_smp = digi_en & (r_div_cnt >= sample_div);

    // Synchronizer chain on the asynchronous entropy input; runs even when disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ro_raw};
        end
    end

    // Sample-rate divider: counts up to sample_div, restarts on each strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (!digi_en || w_smp) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
        end
    end

    // Next-state and emission decode for raw and von Neumann modes.
    always_comb begin
        w_state_nxt = r_state;
        w_first_nxt = r_first;
        w_data_nxt  = r_data_out;
        w_vld_nxt   = 1'b0;
        if (!digi_en || !vn_en) begin
            // Leaving VN mode (or disabling) drops any half pair so a stale
            // first bit can never be emitted later.
            w_state_nxt = ST_IDLE;
            if (w_smp && !vn_en) begin
                w_data_nxt = w_s_bit;
                w_vld_nxt  = 1'b1;
            end else begin
                w_vld_nxt  = 1'b0;
            end
        end else if (w_smp) begin
            case (r_state)
                ST_IDLE: begin
                    w_first_nxt = w_s_bit;
                    w_state_nxt = ST_PAIR;
                end
                ST_PAIR: begin
                    w_state_nxt = ST_IDLE;
                    // 01 -> 0, 10 -> 1, equal pairs are discarded.
                    if (r_first != w_s_bit) begin
                        w_data_nxt = r_first;
                        w_vld_nxt  = 1'b1;
                    end else begin
                        w_vld_nxt  = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Debiaser state, stored first bit and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_first    <= 1'b0;
            r_data_out <= 1'b0;
            r_data_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_first    <= w_first_nxt;
            r_data_out <= w_data_nxt;
            r_data_vld <= w_vld_nxt;
        end
    end

    // Saturating emitted-bit counter; a clear in a strobe cycle drops that bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 16'h0000;
        end else if (cnt_clr) begin
            r_bit_cnt <= 16'h0000;
        end else if (r_data_vld && (r_bit_cnt != CNT_MAX)) begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    assign digi_data_out = r_data_out;
    assign digi_data_vld = r_data_vld;
    assign digi_bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_trng_digitizer.sv
// -----------------------------------------------------------------------------
// tb_trng_digitizer
//
// Directed scenarios plus a randomized run. A behavioural model (sample-bit
// history queue, elapsed-cycle count, pending-pair queue) predicts the outputs
// every cycle; a compare process checks the DUT against it on every falling
// edge. Directed scenarios add literal expectations worked out by hand.
// -----------------------------------------------------------------------------
module tb_trng_digitizer;

    localparam int S  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ro_raw;
    logic          digi_en;
    logic [DW-1:0] sample_div;
    logic          vn_en;
    logic          cnt_clr;
    logic          digi_data_out;
    logic          digi_data_vld;
    logic [15:0]   digi_bit_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trng_digitizer #(.SYNC_STAGES(S), .DIV_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ro_raw        (ro_raw),
        .digi_en       (digi_en),
        .sample_div    (sample_div),
        .vn_en         (vn_en),
        .cnt_clr       (cnt_clr),
        .digi_data_out (digi_data_out),
        .digi_data_vld (digi_data_vld),
        .digi_bit_cnt  (digi_bit_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid = 1'b0;
    bit m_out;
    bit m_vld;
    int m_cnt;
    int m_elapsed;
    bit m_pair[$];
    bit m_hist[$];

    // Model update on each rising edge from the inputs present before the edge.
    always @(posedge clk) begin
        bit s;
        bit nv;
        if (rst) begin
            m_valid   = 1'b1;
            m_out     = 1'b0;
            m_vld     = 1'b0;
            m_cnt     = 0;
            m_elapsed = 0;
            m_pair.delete();
            m_hist.delete();
            for (int k = 0; k < S; k++) m_hist.push_back(1'b0);
        end else if (m_valid) begin
            s  = m_hist[S-1];
            nv = 1'b0;
            if (digi_en && (m_elapsed >= int'(sample_div))) begin
                m_elapsed = 0;
                if (!vn_en) begin
                    nv    = 1'b1;
                    m_out = s;
                end else begin
                    m_pair.push_back(s);
                    if (m_pair.size() == 2) begin
                        if (m_pair[0] != m_pair[1]) begin
                            nv    = 1'b1;
                            m_out = m_pair[0];
                        end
                        m_pair.delete();
                    end
                end
            end else if (digi_en) begin
                m_elapsed++;
            end else begin
                m_elapsed = 0;
            end
            if (!digi_en || !vn_en) m_pair.delete();
            if (cnt_clr) m_cnt = 0;
            else if (m_vld && m_cnt < 65535) m_cnt++;
            m_vld = nv;
            m_hist.push_front(ro_raw);
            void'(m_hist.pop_back());
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_data", digi_data_out, m_out);
            chk("model_vld", digi_data_vld, m_vld);
            chk("model_cnt", digi_bit_cnt, m_cnt[15:0]);
        end
    end

    // ---------------- directed helpers ----------------
    // VN run with sample_div=1: bit b[i] is s_bit at the i-th strobe (cycles
    // 1,3,5,... after enable). vn_en is dropped for one cycle at toggle_c.
    task automatic vn_seq(input logic [15:0] b, input int n, input int toggle_c,
                          input bit keep_en, output int nvld, output logic [15:0] dat);
        int k;
        int i;
        nvld = 0;
        dat  = 16'h0000;
        for (int c = -S; c <= 2 * n; c++) begin
            @(negedge clk);
            if (digi_data_vld) begin
                dat = {dat[14:0], digi_data_out};
                nvld++;
            end
            k = c + S - 1;
            if (k < 0) k = 0;
            i = k / 2;
            if (i > n - 1) i = n - 1;
            ro_raw     = b[i];
            sample_div = 8'd1;
            vn_en      = (c != toggle_c);
            digi_en    = (c >= 0) && (keep_en || c < 2 * n);
        end
    endtask

    int           nv;
    int           last;
    int           vcyc[$];
    logic [15:0]  dat;

    initial begin
        rst = 1'b1; ro_raw = 1'b0; digi_en = 1'b0; vn_en = 1'b0;
        cnt_clr = 1'b0; sample_div = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_out", digi_data_out, 1'b0);
        chk("reset_vld", digi_data_vld, 1'b0);
        chk("reset_cnt", digi_bit_cnt, 16'd0);
        rst = 1'b0;

        // Raw decimation, period 4.
        ro_raw = 1'b1;
        repeat (S + 2) @(negedge clk);
        sample_div = 8'd3; vn_en = 1'b0; digi_en = 1'b1;
        nv = 0; last = -1;
        for (int c = 0; c < 400 && nv < 40; c++) begin
            @(negedge clk);
            if (digi_data_vld) begin
                chk("raw_data", digi_data_out, 1'b1);
                if (last >= 0) chk("raw_gap", c - last, 4);
                last = c;
                nv++;
            end
        end
        chk("raw_strobes", nv, 40);
        digi_en = 1'b0;
        @(negedge clk);
        chk("raw_cnt40", digi_bit_cnt, 16'd40);

        // VN pairs 01 10 11 00.
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        vn_seq(16'h0036, 8, -1, 1'b0, nv, dat);
        chk("vn_count", nv, 2);
        chk("vn_data", dat, 16'h0001);
        @(negedge clk);
        chk("vn_cnt2", digi_bit_cnt, 16'd2);

        // Half-pair drop: 1, vn_en glitch, then 00 and 01.
        vn_seq(16'h0011, 5, 2, 1'b0, nv, dat);
        chk("drop_count", nv, 1);
        chk("drop_data", dat, 16'h0000);

        // Divider shrink, then disable with hold.
        ro_raw = 1'b1; vn_en = 1'b0; sample_div = 8'd200;
        repeat (S + 2) @(negedge clk);
        vcyc.delete();
        for (int c = 0; c <= 120; c++) begin
            @(negedge clk);
            if (digi_data_vld) vcyc.push_back(c);
            if (c >= 92) begin
                chk("dis_vld", digi_data_vld, 1'b0);
                chk("dis_hold", digi_data_out, 1'b1);
            end
            digi_en = (c <= 90);
            if (c == 50) sample_div = 8'd10;
        end
        chk("shrink_count", vcyc.size(), 4);
        if (vcyc.size() >= 3) begin
            chk("shrink_first", vcyc[0], 51);
            chk("shrink_second", vcyc[1], 62);
            chk("shrink_third", vcyc[2], 73);
        end

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ro_raw  = 1'($urandom);
            digi_en = ($urandom % 16) != 0;
            if ((c % 40) == 0) vn_en = ($urandom % 2) != 0;
            if ((c % 50) == 0) sample_div = 8'($urandom % 4);
            cnt_clr = ($urandom % 64) == 0;
            rst     = ($urandom % 700) == 0;
        end
        rst = 1'b0; cnt_clr = 1'b0; digi_en = 1'b0;
        @(negedge clk);

        // Counter saturation and clear-with-strobe.
        ro_raw = 1'b1; cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0; sample_div = 8'd0; vn_en = 1'b0; digi_en = 1'b1;
        repeat (65540) @(negedge clk);
        chk("sat_cnt", digi_bit_cnt, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("sat_hold", digi_bit_cnt, 16'hFFFF);
        chk("sat_vld", digi_data_vld, 1'b1);
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("clr_with_vld", digi_bit_cnt, 16'd0);
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("count_after_clr", digi_bit_cnt, 16'd1);
        digi_en = 1'b0;

        // Reset with the debiaser holding a first bit.
        vn_seq(16'h0001, 1, -1, 1'b1, nv, dat);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_out", digi_data_out, 1'b0);
        chk("rst_vld", digi_data_vld, 1'b0);
        chk("rst_cnt", digi_bit_cnt, 16'd0);
        rst = 1'b0; digi_en = 1'b0;
        vn_seq(16'h0001, 2, -1, 1'b0, nv, dat);
        chk("post_rst_count", nv, 1);
        chk("post_rst_data", dat, 16'h0001);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
